// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
// Frames the granted byte, launches it, tracks tx_active and enforces an idle gap.
module uart_tx_scheduler #(
   parameter int N_REQ         = 4,
   parameter int GAP_CYCLES    = 16,
   parameter int START_TIMEOUT = 15,
   localparam int IDW          = $clog2(N_REQ)
) (
   input  logic                 uart_Clk,
   input  logic                 uart_Rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic [9:0]           tx_frame,
   output logic                 tx_enable,
   input  logic                 tx_active,
   output logic [IDW-1:0]       grant_id,
   output logic                 busy,
   output logic                 err_timeout
);

   localparam int CMAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_START,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t           r_state;
   logic [IDW-1:0]   r_last;
   logic [IDW-1:0]   r_grant;
   logic [CW-1:0]    r_cnt;
   logic [N_REQ-1:0] r_ready;
   logic [9:0]       r_frame;
   logic             r_tx_en;
   logic             r_busy;
   logic             r_err;

   logic [IDW-1:0]   w_idx;
   logic [IDW-1:0]   w_win;
   logic             w_any;
   logic [7:0]       w_win_data;
   logic [N_REQ-1:0] w_onehot;

   // Search starts one past the last grantee, so a held request waits at most N_REQ frames.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_idx = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx = IDW'((int'(r_last) + k) % N_REQ);
         if (!w_any && req_valid[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
         end
      end
   end

   always_comb begin
      w_win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_win == IDW'(i)) w_win_data = req_data[8*i +: 8];
      end
   end

   assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;

   always_ff @(posedge uart_Clk or negedge uart_Rst_n) begin
      if (!uart_Rst_n) begin
         r_state <= S_IDLE;
         r_last  <= IDW'(N_REQ - 1);
         r_grant <= '0;
         r_cnt   <= '0;
         r_ready <= '0;
         r_frame <= 10'h3FF;
         r_tx_en <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ready <= '0;
         r_tx_en <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_frame <= {1'b1, w_win_data, 1'b0};
                  r_grant <= w_win;
                  r_last  <= w_win;
                  r_ready <= w_onehot;
                  r_tx_en <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (tx_active) begin
                  r_state <= S_WAIT_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  // Counter is about to reach START_TIMEOUT: give up, no gap.
                  if (r_cnt == CW'(START_TIMEOUT - 1)) begin
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            S_WAIT_DONE: begin
               if (!tx_active) begin
                  if (GAP_CYCLES == 0) begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt   <= CW'(GAP_CYCLES);
                     r_state <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = r_ready;
   assign tx_frame    = r_frame;
   assign tx_enable   = r_tx_en;
   assign grant_id    = r_grant;
   assign busy        = r_busy;
   assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table-driven arbitration rows with a launch scoreboard,
// plus hand sequences for start timeout, zero-gap relaunch and mid-frame reset.
module tb_uart_tx_scheduler;

   localparam int N   = 4;
   localparam int GAP = 16;
   localparam int TMO = 15;

   typedef struct packed {
      logic [3:0]      valid;
      logic [31:0]     data;
      logic [2:0]      nfr;
      logic [6:0]      txlen;
      logic [4:0][1:0] ids;
   } vec_t;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   logic        clk, rst_n;
   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_data;
   logic [9:0]  tx_frame;
   logic        tx_enable, tx_active, busy, err_timeout;
   logic [1:0]  grant_id;

   logic [3:0]  v2, req_ready2;
   logic [31:0] d2;
   logic [9:0]  tx_frame2;
   logic        tx_enable2, tx_active2, busy2, err_timeout2;
   logic [1:0]  grant_id2;

   uart_tx_scheduler #(.N_REQ(N), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
      .uart_Clk(clk), .uart_Rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_frame(tx_frame), .tx_enable(tx_enable),
      .tx_active(tx_active), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout));

   uart_tx_scheduler #(.N_REQ(N), .GAP_CYCLES(0), .START_TIMEOUT(TMO)) dut_g0 (
      .uart_Clk(clk), .uart_Rst_n(rst_n), .req_valid(v2), .req_data(d2),
      .req_ready(req_ready2), .tx_frame(tx_frame2), .tx_enable(tx_enable2),
      .tx_active(tx_active2), .grant_id(grant_id2), .busy(busy2), .err_timeout(err_timeout2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   launches = 0;
   int   t_fall = 0;
   bit   fall_pending = 0;
   bit   tx_nostart = 0;
   int   tx_len = 20;
   logic prev_busy = 1'b0;
   exp_t sbq[$];
   exp_t m_e;
   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input int n,
                               input int len, input logic [1:0] i0, input logic [1:0] i1,
                               input logic [1:0] i2, input logic [1:0] i3, input logic [1:0] i4);
      vec_t r;
      r.valid = v;
      r.data  = d;
      r.nfr   = 3'(n);
      r.txlen = 7'(len);
      r.ids   = {i4, i3, i2, i1, i0};
      return r;
   endfunction

   task automatic push_exp(input logic [1:0] id, input logic [31:0] d);
      exp_t x;
      x.id   = id;
      x.data = d[8*id +: 8];
      sbq.push_back(x);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: goes active the edge after a launch, stays for tx_len clocks.
   initial begin
      tx_active = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && tx_enable && !tx_nostart) begin
            @(posedge clk); #1 tx_active = 1'b1;
            repeat (tx_len) @(posedge clk);
            #1 tx_active = 1'b0;
            t_fall = cyc;
            fall_pending = 1;
         end
      end
   end

   // Launch monitor: pops the scoreboard on each tx_enable and times the idle gap.
   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_enable) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: launch for grant_id=%0d with nothing expected", grant_id);
            end else begin
               m_e = sbq.pop_front();
               chk("sb_ready", 32'(req_ready), 32'(4'b0001 << m_e.id));
               chk("sb_grant_id", 32'(grant_id), 32'(m_e.id));
               chk("sb_frame", 32'(tx_frame), 32'({1'b1, m_e.data, 1'b0}));
               chk("sb_busy", 32'(busy), 32'(1));
            end
            launches++;
         end else begin
            chk("ready_without_enable", 32'(req_ready), 32'(0));
         end
         if (prev_busy && !busy && fall_pending) begin
            chk("gap_len", 32'(cyc - t_fall), 32'(GAP + 1));
            fall_pending = 0;
         end
      end
      prev_busy = busy;
   end

   task automatic wait_launches(input int target, input int budget, input string name);
      int n = 0;
      while (launches < target && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, 32'(launches >= target), 32'(1));
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      chk(name, 32'(busy), 32'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      rst_n = 1'b0; req_valid = '0; req_data = '0;
      v2 = '0; d2 = '0; tx_active2 = 1'b0;

      tbl[0] = mk(4'b1111, 32'h13121110, 5, 20,  2'd0, 2'd1, 2'd2, 2'd3, 2'd0);
      tbl[1] = mk(4'b0001, 32'h000000A5, 1, 100, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
      tbl[2] = mk(4'b0010, 32'hC3B2A190, 1, 20,  2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
      tbl[3] = mk(4'b1001, 32'h5A000069, 2, 20,  2'd3, 2'd0, 2'd0, 2'd0, 2'd0);
      tbl[4] = mk(4'b0110, 32'h00EE7700, 2, 20,  2'd1, 2'd2, 2'd0, 2'd0, 2'd0);
      tbl[5] = mk(4'b1011, 32'hD400B2C1, 3, 20,  2'd3, 2'd0, 2'd1, 2'd0, 2'd0);

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'(0));
      chk("rst_frame", 32'(tx_frame), 32'h3FF);
      chk("rst_enable", 32'(tx_enable), 32'(0));
      chk("rst_grant", 32'(grant_id), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_err", 32'(err_timeout), 32'(0));
      @(posedge clk); #1 rst_n = 1'b1;

      for (int r = 0; r < 6; r++) begin
         tx_len   = int'(tbl[r].txlen);
         req_data = tbl[r].data;
         for (int k = 0; k < int'(tbl[r].nfr); k++) push_exp(tbl[r].ids[k], tbl[r].data);
         base = launches;
         @(posedge clk); #1 req_valid = tbl[r].valid;
         @(posedge clk); @(negedge clk);
         chk("row_first_latency", 32'(tx_enable), 32'(1));
         wait_launches(base + int'(tbl[r].nfr), 400 * int'(tbl[r].nfr), "row_launches");
         req_valid = '0;
         wait_idle(300, "row_idle");
         chk("row_sb_drained", 32'(sbq.size()), 32'(0));
      end

      // Start timeout: transmitter never goes active; second request relaunches with no gap.
      tx_nostart = 1;
      req_data = 32'h00007E81;
      push_exp(2'd0, req_data);
      push_exp(2'd1, req_data);
      base = launches;
      @(posedge clk); #1 req_valid = 4'b0011;
      @(posedge clk); @(negedge clk);
      chk("tmo_launch0", 32'(tx_enable), 32'(1));
      repeat (TMO) @(negedge clk);
      chk("tmo_err_early", 32'(err_timeout), 32'(0));
      @(negedge clk);
      chk("tmo_err_pulse", 32'(err_timeout), 32'(1));
      chk("tmo_busy_low", 32'(busy), 32'(0));
      @(negedge clk);
      chk("tmo_relaunch_no_gap", 32'(tx_enable), 32'(1));
      chk("tmo_err_one_cycle", 32'(err_timeout), 32'(0));
      req_valid = '0;
      wait_idle(100, "tmo_idle");
      chk("tmo_launch_count", 32'(launches - base), 32'(2));
      tx_nostart = 0;

      // Zero-gap instance: relaunch two clocks after tx_active falls.
      d2 = 32'h0000003C;
      @(posedge clk); #1 v2 = 4'b0001;
      @(posedge clk); @(negedge clk);
      chk("g0_launch", 32'(tx_enable2), 32'(1));
      chk("g0_ready", 32'(req_ready2), 32'(1));
      @(posedge clk); #1 tx_active2 = 1'b1;
      repeat (5) @(posedge clk);
      #1 tx_active2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("g0_no_launch_yet", 32'(tx_enable2), 32'(0));
      chk("g0_busy_low", 32'(busy2), 32'(0));
      @(negedge clk);
      chk("g0_relaunch_2cyc", 32'(tx_enable2), 32'(1));
      chk("g0_frame", 32'(tx_frame2), 32'h278);
      chk("g0_ready2", 32'(req_ready2), 32'(1));
      v2 = '0;
      n = 0;
      do begin @(negedge clk); n++; end while (busy2 && n < 60);
      chk("g0_idle", 32'(busy2), 32'(0));

      // Reset during WAIT_DONE: outputs drop at once, pointer restarts at requester 0.
      tx_len = 100;
      req_data = 32'h00550000;
      push_exp(2'd2, req_data);
      base = launches;
      @(posedge clk); #1 req_valid = 4'b0100;
      wait_launches(base + 1, 10, "rst_launch");
      req_valid = '0;
      n = 0;
      while (!tx_active && n < 10) begin @(posedge clk); #2; n++; end
      chk("rst_tx_went_active", 32'(tx_active), 32'(1));
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(req_ready), 32'(0));
      chk("mid_rst_frame", 32'(tx_frame), 32'h3FF);
      chk("mid_rst_enable", 32'(tx_enable), 32'(0));
      chk("mid_rst_grant", 32'(grant_id), 32'(0));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_err", 32'(err_timeout), 32'(0));
      n = 0;
      while (tx_active && n < 200) begin @(posedge clk); #2; n++; end
      chk("rst_tx_done", 32'(tx_active), 32'(0));
      fall_pending = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      req_data = 32'h44332211;
      push_exp(2'd0, req_data);
      base = launches;
      @(posedge clk); #1 req_valid = 4'b1111;
      @(posedge clk); @(negedge clk);
      chk("post_rst_latency", 32'(tx_enable), 32'(1));
      wait_launches(base + 1, 10, "post_rst_launch");
      req_valid = '0;
      wait_idle(300, "post_rst_idle");

      chk("sb_empty_end", 32'(sbq.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
